// File: rtl/angle_poll_master.sv
// Avalon-MM read initiator that periodically polls the steering-angle PIO data register
// and presents each sample with a one-cycle valid strobe and a change flag.
module angle_poll_master #(
    parameter int POLL_DIV     = 50000,
    parameter int DATA_W       = 12,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              poll_now,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] angle,
    output logic              angle_valid,
    output logic              angle_changed,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(POLL_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [LAT_W-1:0]  lat_q;
    logic              avm_read_q;
    logic [DATA_W-1:0] angle_q;
    logic              angle_valid_q;
    logic              angle_changed_q;
    logic              busy_q;
    logic              timeout_err_q;
    logic              trigger;
    logic [31:0]       rd_unused;

    // Only the low DATA_W bits of readdata carry the angle.
    assign rd_unused = avm_readdata;

    // poll_now and a period expiry in the same cycle collapse into one trigger.
    assign trigger = (state_q == IDLE) && (poll_now || (enable && (cnt_q == CNT_LAST)));

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (state_q == IDLE) begin
            cnt_d = trigger ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            to_cnt_q        <= '0;
            lat_q           <= '0;
            avm_read_q      <= 1'b0;
            angle_q         <= '0;
            angle_valid_q   <= 1'b0;
            angle_changed_q <= 1'b0;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            angle_valid_q   <= 1'b0;
            angle_changed_q <= 1'b0;
            if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q    <= REQ;
                        avm_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                        to_cnt_q   <= '0;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        state_q    <= WAIT_DATA;
                        avm_read_q <= 1'b0;
                        lat_q      <= LAT_LOAD;
                    end else if (to_cnt_q == TO_LAST) begin
                        // Timeout set overrides a simultaneous err_clr.
                        state_q       <= IDLE;
                        avm_read_q    <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_DATA: begin
                    if (lat_q == LAT_W'(1)) begin
                        // angle_q doubles as the previous-sample register.
                        angle_q         <= avm_readdata[DATA_W-1:0];
                        angle_changed_q <= (avm_readdata[DATA_W-1:0] != angle_q);
                        angle_valid_q   <= 1'b1;
                        state_q         <= DONE;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    avm_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address   = 2'b00;
    assign avm_read      = avm_read_q;
    assign angle         = angle_q;
    assign angle_valid   = angle_valid_q;
    assign angle_changed = angle_changed_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign dbg_state     = state_q;

endmodule
